// File: rtl/mysystem_dpram.sv
// Dual-port on-chip RAM with two Avalon-MM slave ports.
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | zero-fill sweep over 0..DEPTH-1, both ports stalled
// READY | normal operation, s2 stalled only on same-address write clash
module mysystem_dpram #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int DEPTH          = 3250,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_NEW_DATA   = 1,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state;
    logic                    wait_q;
    logic [ADDR_WIDTH-1:0]   sweep;
    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    logic s1_in, s2_in, s1_wr_req, s2_wr_req, collide;
    logic s1_acc, s2_acc, s1_wr, s2_wr, s1_rd, s2_rd;
    logic [DATA_WIDTH-1:0] rd1_word, rd2_word;
    logic                  v1_a, v1_b, v2_a, v2_b;
    logic [DATA_WIDTH-1:0] d1_a, d1_b, d2_a, d2_b;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return res;
    endfunction

    assign s1_in = {1'b0, s1_address} < DEPTH_EXT;
    assign s2_in = {1'b0, s2_address} < DEPTH_EXT;

    // s1 wins a same-address write clash; s2 is held off and retries
    assign s1_wr_req = s1_chipselect & s1_write & ~wait_q;
    assign s2_wr_req = s2_chipselect & s2_write & ~wait_q;
    assign collide   = s1_wr_req & s2_wr_req & s1_in & (s1_address == s2_address);

    assign s1_waitrequest = wait_q;
    assign s2_waitrequest = wait_q | collide;

    assign s1_acc = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest & clken;
    assign s2_acc = s2_chipselect & (s2_read | s2_write) & ~s2_waitrequest & clken;
    assign s1_wr  = s1_acc & s1_write;
    assign s2_wr  = s2_acc & s2_write;
    assign s1_rd  = s1_acc & ~s1_write;
    assign s2_rd  = s2_acc & ~s2_write;

    // Read word per port, with optional bypass of the other port's same-cycle write
    always_comb begin
        rd1_word = '0;
        rd2_word = '0;
        if (s1_in) begin
            if (RDW_NEW_DATA != 0 && s2_wr && s2_address == s1_address)
                rd1_word = merge_bytes(mem[s1_address], s2_writedata, s2_byteenable);
            else
                rd1_word = mem[s1_address];
        end
        if (s2_in) begin
            if (RDW_NEW_DATA != 0 && s1_wr && s1_address == s2_address)
                rd2_word = merge_bytes(mem[s2_address], s1_writedata, s1_byteenable);
            else
                rd2_word = mem[s2_address];
        end
    end

    // Sequencing FSM: zero-fill sweep, then release the ports
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            sweep  <= '0;
            wait_q <= 1'b1;
        end else if (clken) begin
            case (state)
                ST_CLEAR: begin
                    if (sweep == LAST_ADDR) begin
                        state  <= ST_READY;
                        wait_q <= 1'b0;
                    end else begin
                        sweep <= sweep + 1'b1;
                    end
                end
                default: wait_q <= 1'b0;
            endcase
        end
    end

    // Memory array: sweep writes during CLEAR, byte-merged port writes otherwise
    always_ff @(posedge clk) begin
        if (clken) begin
            if (state == ST_CLEAR) begin
                mem[sweep] <= '0;
            end else begin
                if (s1_wr && s1_in)
                    mem[s1_address] <= merge_bytes(mem[s1_address], s1_writedata, s1_byteenable);
                if (s2_wr && s2_in)
                    mem[s2_address] <= merge_bytes(mem[s2_address], s2_writedata, s2_byteenable);
            end
        end
    end

    // Read pipelines; data registers load only on accepted reads so outputs hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_a <= 1'b0; v2_a <= 1'b0; d1_a <= '0; d2_a <= '0;
            v1_b <= 1'b0; v2_b <= 1'b0; d1_b <= '0; d2_b <= '0;
        end else if (clken) begin
            v1_a <= s1_rd;
            v1_b <= s2_rd;
            if (s1_rd) d1_a <= rd1_word;
            if (s2_rd) d1_b <= rd2_word;
            v2_a <= v1_a;
            v2_b <= v1_b;
            d2_a <= d1_a;
            d2_b <= d1_b;
        end
    end

    assign s1_readdatavalid = (READ_LATENCY == 2) ? v2_a : v1_a;
    assign s1_readdata      = (READ_LATENCY == 2) ? d2_a : d1_a;
    assign s2_readdatavalid = (READ_LATENCY == 2) ? v2_b : v1_b;
    assign s2_readdata      = (READ_LATENCY == 2) ? d2_b : d1_b;

endmodule

// File: tb/tb_mysystem_dpram.sv
// Bench for mysystem_dpram: two instances share stimulus.
// dut_a: latency 1, new-data bypass, zero-fill after reset.
// dut_b: latency 2, old-data on read-during-write, no zero-fill.
module tb_mysystem_dpram;

    logic        clk = 1'b0;
    logic        reset_n, clken;
    logic [11:0] s1_address, s2_address;
    logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata;

    logic [31:0] a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata;
    logic        a_s1_rdv, a_s2_rdv, b_s1_rdv, b_s2_rdv;
    logic        a_s1_wait, a_s2_wait, b_s1_wait, b_s2_wait;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mysystem_dpram #(.READ_LATENCY(1), .RDW_NEW_DATA(1), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(a_s1_readdata), .s1_readdatavalid(a_s1_rdv), .s1_waitrequest(a_s1_wait),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(a_s2_readdata), .s2_readdatavalid(a_s2_rdv), .s2_waitrequest(a_s2_wait)
    );

    mysystem_dpram #(.READ_LATENCY(2), .RDW_NEW_DATA(0), .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(b_s1_readdata), .s1_readdatavalid(b_s1_rdv), .s1_waitrequest(b_s1_wait),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(b_s2_readdata), .s2_readdatavalid(b_s2_rdv), .s2_waitrequest(b_s2_wait)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s1_chipselect = 0; s1_read = 0; s1_write = 0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0;
    endtask

    task automatic do_write(input int port, input logic [11:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
        if (port == 1) begin
            s1_chipselect = 1; s1_write = 1; s1_address = addr; s1_writedata = data; s1_byteenable = be;
        end else begin
            s2_chipselect = 1; s2_write = 1; s2_address = addr; s2_writedata = data; s2_byteenable = be;
        end
        tick();
        idle();
    endtask

    // Read on one port; dut_a must answer one cycle after acceptance, dut_b two
    task automatic do_read(input int port, input logic [11:0] addr, input logic [31:0] exp_a,
                           input logic [31:0] exp_b, input bit chk_b, input string name);
        logic        va, vb;
        logic [31:0] da, db;
        if (port == 1) begin
            s1_chipselect = 1; s1_read = 1; s1_address = addr;
        end else begin
            s2_chipselect = 1; s2_read = 1; s2_address = addr;
        end
        tick();
        idle();
        va = (port == 1) ? a_s1_rdv : a_s2_rdv;
        da = (port == 1) ? a_s1_readdata : a_s2_readdata;
        vb = (port == 1) ? b_s1_rdv : b_s2_rdv;
        n_vec++;
        if (va !== 1'b1 || da !== exp_a) begin
            n_err++;
            $display("FAIL %s lat1: valid=%b data=%h, required valid=1 data=%h", name, va, da, exp_a);
        end
        if (chk_b) begin
            n_vec++;
            if (vb !== 1'b0) begin
                n_err++;
                $display("FAIL %s lat2 early: valid=%b, required 0", name, vb);
            end
        end
        tick();
        va = (port == 1) ? a_s1_rdv : a_s2_rdv;
        vb = (port == 1) ? b_s1_rdv : b_s2_rdv;
        db = (port == 1) ? b_s1_readdata : b_s2_readdata;
        n_vec++;
        if (va !== 1'b0) begin
            n_err++;
            $display("FAIL %s lat1 pulse: valid=%b, required 0", name, va);
        end
        if (chk_b) begin
            n_vec++;
            if (vb !== 1'b1 || db !== exp_b) begin
                n_err++;
                $display("FAIL %s lat2: valid=%b data=%h, required valid=1 data=%h", name, vb, db, exp_b);
            end
        end
    endtask

    // Counts edges until dut_a releases waitrequest, bounded
    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (a_s1_wait === 1'b1 && n < 5000) begin
            tick();
            n++;
            if (n == 1) begin
                n_vec++;
                if (b_s1_wait !== 1'b0 || b_s2_wait !== 1'b0 || a_s2_wait !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s first edge: b_wait=%b%b a_s2_wait=%b, required 00 1",
                             name, b_s1_wait, b_s2_wait, a_s2_wait);
                end
            end
        end
        n_vec++;
        if (n != 3250) begin
            n_err++;
            $display("FAIL %s sweep length: %0d cycles, required 3250", name, n);
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if (a_s1_wait !== 1 || a_s2_wait !== 1 || b_s1_wait !== 1 || b_s2_wait !== 1) begin
            n_err++;
            $display("FAIL reset wait: %b%b%b%b, required 1111", a_s1_wait, a_s2_wait, b_s1_wait, b_s2_wait);
        end
        n_vec++;
        if (a_s1_rdv !== 0 || a_s2_rdv !== 0 || b_s1_rdv !== 0 || b_s2_rdv !== 0 ||
            a_s1_readdata !== 0 || b_s2_readdata !== 0) begin
            n_err++;
            $display("FAIL reset outputs: rdv=%b%b%b%b data=%h/%h, required 0",
                     a_s1_rdv, a_s2_rdv, b_s1_rdv, b_s2_rdv, a_s1_readdata, b_s2_readdata);
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        reset_n = 1;
        wait_clear("clear");
        do_read(1, 12'd0,    32'h0, 32'h0, 0, "clear addr0");
        do_read(2, 12'd1625, 32'h0, 32'h0, 0, "clear addr1625");
        do_read(1, 12'd3249, 32'h0, 32'h0, 0, "clear addr3249");
    endtask

    task automatic test_byte_merge();
        do_write(1, 12'd5, 32'hDEADBEEF, 4'hF);
        do_write(2, 12'd5, 32'h000000AA, 4'h1);
        do_read(1, 12'd5, 32'hDEADBEAA, 32'hDEADBEAA, 1, "byte merge");
    endtask

    task automatic test_collision();
        s1_chipselect = 1; s1_write = 1; s1_address = 12'd9; s1_writedata = 32'h11111111; s1_byteenable = 4'hF;
        s2_chipselect = 1; s2_write = 1; s2_address = 12'd9; s2_writedata = 32'h22222222; s2_byteenable = 4'hF;
        #1;
        n_vec++;
        if (a_s2_wait !== 1 || b_s2_wait !== 1 || a_s1_wait !== 0) begin
            n_err++;
            $display("FAIL collision stall: s2_wait=%b/%b s1_wait=%b, required 1/1 0", a_s2_wait, b_s2_wait, a_s1_wait);
        end
        tick();
        s1_writedata = 32'h33333333;
        #1;
        n_vec++;
        if (a_s2_wait !== 1) begin
            n_err++;
            $display("FAIL collision repeat: s2_wait=%b, required 1", a_s2_wait);
        end
        tick();
        s1_chipselect = 0; s1_write = 0;
        #1;
        n_vec++;
        if (a_s2_wait !== 0 || b_s2_wait !== 0) begin
            n_err++;
            $display("FAIL collision release: s2_wait=%b/%b, required 0/0", a_s2_wait, b_s2_wait);
        end
        tick();
        idle();
        do_read(1, 12'd9, 32'h22222222, 32'h22222222, 1, "collision result");
    endtask

    task automatic test_rdw();
        do_write(2, 12'd3, 32'hAAAA5555, 4'hF);
        s1_chipselect = 1; s1_write = 1; s1_address = 12'd3; s1_writedata = 32'h12345678; s1_byteenable = 4'hF;
        s2_chipselect = 1; s2_read = 1; s2_address = 12'd3;
        tick();
        idle();
        n_vec++;
        if (a_s2_rdv !== 1 || a_s2_readdata !== 32'h12345678) begin
            n_err++;
            $display("FAIL rdw new: valid=%b data=%h, required valid=1 data=12345678", a_s2_rdv, a_s2_readdata);
        end
        tick();
        n_vec++;
        if (b_s2_rdv !== 1 || b_s2_readdata !== 32'hAAAA5555) begin
            n_err++;
            $display("FAIL rdw old: valid=%b data=%h, required valid=1 data=aaaa5555", b_s2_rdv, b_s2_readdata);
        end
        do_read(2, 12'd3, 32'h12345678, 32'h12345678, 1, "rdw after");
    endtask

    task automatic test_out_of_range();
        do_write(1, 12'd3249, 32'h0BADF00D, 4'hF);
        do_write(1, 12'd4000, 32'hFFFFFFFF, 4'hF);
        do_read(1, 12'd4000, 32'h0, 32'h0, 1, "oor read");
        do_read(2, 12'd3249, 32'h0BADF00D, 32'h0BADF00D, 1, "oor neighbour");
    endtask

    task automatic test_back_to_back();
        logic [11:0] ad [3];
        logic [31:0] ex [3];
        ad[0] = 12'd5; ad[1] = 12'd9; ad[2] = 12'd3;
        ex[0] = 32'hDEADBEAA; ex[1] = 32'h22222222; ex[2] = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                s1_chipselect = 1; s1_read = 1; s1_address = ad[i];
            end else begin
                idle();
            end
            tick();
            if (i < 3) begin
                n_vec++;
                if (a_s1_rdv !== 1 || a_s1_readdata !== ex[i]) begin
                    n_err++;
                    $display("FAIL b2b lat1 #%0d: valid=%b data=%h, required valid=1 data=%h", i, a_s1_rdv, a_s1_readdata, ex[i]);
                end
            end
            if (i >= 1) begin
                n_vec++;
                if (b_s1_rdv !== 1 || b_s1_readdata !== ex[i-1]) begin
                    n_err++;
                    $display("FAIL b2b lat2 #%0d: valid=%b data=%h, required valid=1 data=%h", i, b_s1_rdv, b_s1_readdata, ex[i-1]);
                end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_clken_stall();
        s1_chipselect = 1; s1_read = 1; s1_address = 12'd5;
        tick();
        idle();
        clken = 0;
        s2_chipselect = 1; s2_read = 1; s2_address = 12'd9;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (a_s1_rdv !== 1 || a_s1_readdata !== 32'hDEADBEAA || b_s1_rdv !== 0) begin
                n_err++;
                $display("FAIL clken hold #%0d: a valid=%b data=%h b valid=%b, required 1 deadbeaa 0",
                         k, a_s1_rdv, a_s1_readdata, b_s1_rdv);
            end
        end
        idle();
        clken = 1;
        tick();
        n_vec++;
        if (a_s1_rdv !== 0 || a_s2_rdv !== 0 || b_s1_rdv !== 1 || b_s1_readdata !== 32'hDEADBEAA) begin
            n_err++;
            $display("FAIL clken resume: a valid=%b/%b b valid=%b data=%h, required 0/0 1 deadbeaa",
                     a_s1_rdv, a_s2_rdv, b_s1_rdv, b_s1_readdata);
        end
        tick();
        n_vec++;
        if (b_s2_rdv !== 0 || b_s1_rdv !== 0) begin
            n_err++;
            $display("FAIL clken no accept: b valid=%b/%b, required 0/0", b_s1_rdv, b_s2_rdv);
        end
    endtask

    task automatic test_reset_mid_clear();
        reset_n = 0;
        #1;
        n_vec++;
        if (a_s1_wait !== 1 || b_s1_wait !== 1 || a_s1_readdata !== 0 || b_s1_readdata !== 0) begin
            n_err++;
            $display("FAIL async reset: wait=%b/%b data=%h/%h, required 1/1 0/0",
                     a_s1_wait, b_s1_wait, a_s1_readdata, b_s1_readdata);
        end
        reset_n = 1;
        for (int k = 0; k < 100; k++) tick();
        n_vec++;
        if (a_s1_wait !== 1) begin
            n_err++;
            $display("FAIL mid sweep: wait=%b, required 1", a_s1_wait);
        end
        reset_n = 0;
        #3;
        reset_n = 1;
        wait_clear("restart");
    endtask

    initial begin
        reset_n = 0;
        clken = 1;
        s1_address = 0; s2_address = 0;
        s1_byteenable = 0; s2_byteenable = 0;
        s1_writedata = 0; s2_writedata = 0;
        idle();
        #23;
        test_reset();
        test_clear();
        test_byte_merge();
        test_collision();
        test_rdw();
        test_out_of_range();
        test_back_to_back();
        test_clken_stall();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
